// File: rtl/register_file_if.sv
// Bundles the register file's read, write and busy-mark signals between the
// decoder/writeback side (master) and the register file (slave).
interface register_file_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] read1_id;
    logic [WIDTH-1:0]  read1_value;
    logic              read1_busy;
    logic [ADDR_W-1:0] read2_id;
    logic [WIDTH-1:0]  read2_value;
    logic              read2_busy;
    logic              write_en;
    logic [ADDR_W-1:0] write_id;
    logic [WIDTH-1:0]  write_value;
    logic              mark_en;
    logic [ADDR_W-1:0] mark_id;

    modport master (
        output read1_id, read2_id,
        output write_en, write_id, write_value,
        output mark_en, mark_id,
        input  read1_value, read1_busy, read2_value, read2_busy
    );

    modport slave (
        input  read1_id, read2_id,
        input  write_en, write_id, write_value,
        input  mark_en, mark_id,
        output read1_value, read1_busy, read2_value, read2_busy
    );
endinterface

// File: rtl/register_file.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard. Define REGFILE_BYPASS_EN to forward writes.
module register_file #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 12
) (
    input  logic           clock,
    input  logic           reset,
    register_file_if.slave rf
);

    if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("register_file: DEPTH must be in 2..2**ADDR_W");
    end

    // Register 0 has no storage; it reads as zero and is never busy.
    logic [WIDTH-1:0] regs [1:DEPTH-1];
    logic [DEPTH-1:1] busy;

    logic [WIDTH-1:0] stored1_value;
    logic [WIDTH-1:0] stored2_value;
    logic             stored1_busy;
    logic             stored2_busy;
    logic             write_ok;
    logic             mark_ok;

    function automatic logic id_valid(input logic [ADDR_W-1:0] id);
        return (id != '0) && (int'(id) < DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] stored_value(input logic [ADDR_W-1:0] id);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (id == ADDR_W'(i)) v = regs[i];
        end
        return v;
    endfunction

    function automatic logic stored_busy(input logic [ADDR_W-1:0] id);
        logic b;
        b = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (id == ADDR_W'(i)) b = busy[i];
        end
        return b;
    endfunction

    assign write_ok = rf.write_en && id_valid(rf.write_id);
    assign mark_ok  = rf.mark_en  && id_valid(rf.mark_id);

    // The mark is applied after the write so a same-edge mark leaves busy set:
    // it belongs to a newer load than the data being written back.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (write_ok && rf.write_id == ADDR_W'(i)) begin
                    regs[i] <= rf.write_value;
                    busy[i] <= 1'b0;
                end
                if (mark_ok && rf.mark_id == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stored1_value = stored_value(rf.read1_id);
        stored1_busy  = stored_busy(rf.read1_id);
        stored2_value = stored_value(rf.read2_id);
        stored2_busy  = stored_busy(rf.read2_id);
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = write_ok && (rf.write_id == rf.read1_id);
    assign hit2 = write_ok && (rf.write_id == rf.read2_id);

    // Forwarded data is by definition the completed load, so busy reads clear.
    assign rf.read1_value = hit1 ? rf.write_value : stored1_value;
    assign rf.read1_busy  = hit1 ? 1'b0 : stored1_busy;
    assign rf.read2_value = hit2 ? rf.write_value : stored2_value;
    assign rf.read2_busy  = hit2 ? 1'b0 : stored2_busy;
`else
    assign rf.read1_value = stored1_value;
    assign rf.read1_busy  = stored1_busy;
    assign rf.read2_value = stored2_value;
    assign rf.read2_busy  = stored2_busy;
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read results
// from an array model, a negedge monitor pops and compares them.
module tb_register_file;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;

    register_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) rf ();

    register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .rf    (rf)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [7:0] v1;
        logic       b1;
        logic [7:0] v2;
        logic       b2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: a plain array indexed by id; ids outside 1..DEPTH-1 stay 0.
    logic [7:0] m_val  [0:15];
    logic       m_busy [0:15];

    function automatic bit implemented(input int id);
        return id >= 1 && id < DEPTH;
    endfunction

    function automatic logic [7:0] model_value(input int id);
`ifdef REGFILE_BYPASS_EN
        if (rf.write_en && implemented(int'(rf.write_id)) && int'(rf.write_id) == id)
            return rf.write_value;
`endif
        return implemented(id) ? m_val[id] : 8'h00;
    endfunction

    function automatic logic model_busy(input int id);
`ifdef REGFILE_BYPASS_EN
        if (rf.write_en && implemented(int'(rf.write_id)) && int'(rf.write_id) == id)
            return 1'b0;
`endif
        return implemented(id) ? m_busy[id] : 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_val[i]  = 8'h00;
            m_busy[i] = 1'b0;
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, queues the expected
    // reads, then advances the model across the next rising edge.
    task automatic step(input logic rst_v, input logic we, input logic [3:0] wid,
                        input logic [7:0] wv, input logic me, input logic [3:0] mid,
                        input logic [3:0] r1, input logic [3:0] r2, input string tag);
        exp_t e;
        reset          = rst_v;
        rf.write_en    = we;
        rf.write_id    = wid;
        rf.write_value = wv;
        rf.mark_en     = me;
        rf.mark_id     = mid;
        rf.read1_id    = r1;
        rf.read2_id    = r2;
        if (rst_v) clear_model();
        e.tag = tag;
        e.v1  = model_value(int'(r1));
        e.b1  = model_busy(int'(r1));
        e.v2  = model_value(int'(r2));
        e.b2  = model_busy(int'(r2));
        exp_q.push_back(e);
        @(posedge clock);
        if (!reset) begin
            if (we && implemented(int'(wid))) begin
                m_val[wid]  = wv;
                m_busy[wid] = 1'b0;
            end
            if (me && implemented(int'(mid))) m_busy[mid] = 1'b1;
        end
        #1;
    endtask

    task automatic rd(input logic [3:0] r1, input logic [3:0] r2, input string tag);
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, r1, r2, tag);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (rf.read1_value !== e.v1) begin
                miscompares++;
                $display("FAIL %s read1_value: got %h expected %h", e.tag, rf.read1_value, e.v1);
            end
            if (rf.read1_busy !== e.b1) begin
                miscompares++;
                $display("FAIL %s read1_busy: got %b expected %b", e.tag, rf.read1_busy, e.b1);
            end
            if (rf.read2_value !== e.v2) begin
                miscompares++;
                $display("FAIL %s read2_value: got %h expected %h", e.tag, rf.read2_value, e.v2);
            end
            if (rf.read2_busy !== e.b2) begin
                miscompares++;
                $display("FAIL %s read2_busy: got %b expected %b", e.tag, rf.read2_busy, e.b2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        rf.write_en = 1'b0; rf.write_id = '0; rf.write_value = '0;
        rf.mark_en = 1'b0; rf.mark_id = '0; rf.read1_id = '0; rf.read2_id = '0;
        @(posedge clock);
        #1;

        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd3, 4'd4, "reset_hold");
        rd(4'd3, 4'd4, "after_reset");
        rd(4'd14, 4'd0, "out_of_range_read");

        step(1'b0, 1'b1, 4'd2, 8'h55, 1'b0, 4'd0, 4'd2, 4'd3, "write_id2_same_cycle");
        rd(4'd2, 4'd3, "write_id2_visible");
        step(1'b0, 1'b1, 4'd0, 8'hAA, 1'b0, 4'd0, 4'd2, 4'd0, "write_id0");
        step(1'b0, 1'b1, 4'd13, 8'hAA, 1'b0, 4'd0, 4'd0, 4'd13, "write_id13");
        rd(4'd0, 4'd13, "dropped_writes");
        rd(4'd2, 4'd13, "id2_kept");

        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 4'd5, 4'd2, "mark_id5");
        rd(4'd5, 4'd5, "id5_busy");
        step(1'b0, 1'b1, 4'd5, 8'h12, 1'b0, 4'd0, 4'd5, 4'd0, "write_id5");
        rd(4'd5, 4'd0, "id5_written");
        step(1'b0, 1'b1, 4'd5, 8'h34, 1'b1, 4'd5, 4'd5, 4'd5, "write_mark_id5");
        rd(4'd5, 4'd5, "id5_rebusy");
        step(1'b0, 1'b1, 4'd3, 8'h77, 1'b1, 4'd4, 4'd3, 4'd4, "write3_mark4");
        rd(4'd3, 4'd4, "write3_mark4_both");

        step(1'b0, 1'b1, 4'd2, 8'h55, 1'b0, 4'd0, 4'd2, 4'd5, "reload_id2");
        step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 4'd2, 4'd5, "mark_id2");
        rd(4'd2, 4'd5, "id2_busy_before_reset");
        step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd2, 4'd5, "async_reset");
        step(1'b0, 1'b1, 4'd6, 8'h99, 1'b1, 4'd6, 4'd6, 4'd2, "release_reset");
        rd(4'd6, 4'd2, "after_release");

        step(1'b0, 1'b1, 4'd7, 8'h3C, 1'b0, 4'd0, 4'd7, 4'd7, "write_id7_same_cycle");
        rd(4'd7, 4'd7, "id7_after_edge");
        step(1'b0, 1'b1, 4'd9, 8'hF0, 1'b1, 4'd9, 4'd9, 4'd1, "write_mark_id9_same_cycle");
        step(1'b0, 1'b1, 4'd9, 8'hF0, 1'b0, 4'd0, 4'd9, 4'd9, "rewrite_id9");
        rd(4'd9, 4'd9, "dual_port_id9");

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
        end

        reset = 1'b0;
        rf.write_en = 1'b0;
        rf.mark_en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
